hc4_ram_arbiter: RTL and testbench

// - Shares the HC4 4-bit data RAM between the CPU core port and a host/debug port.
// - Single-port synchronous RAM; at most one access per clk.
// - Round-robin arbitration, plus a bounded host burst-lock for debug dumps and preloads.
// - Sits between the core's RAM access and the debug loader, in the same clock domain.

---
 rtl/hc4_arb_pkg.sv | 18 +
 rtl/hc4_ram_arbiter_if.sv | 39 +++
 rtl/hc4_ram_sp.sv | 20 ++
 rtl/hc4_ram_arbiter.sv | 118 +++++++++++
 tb/tb_hc4_ram_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hc4_arb_pkg.sv
// hc4_arb_pkg: shared types and default sizes for the HC4 RAM arbiter.
package hc4_arb_pkg;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 4;
   localparam int DEF_MAX_BURST = 4;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

// File: rtl/hc4_ram_arbiter_if.sv
// hc4_ram_arbiter_if: CPU and host RAM access ports of the HC4 arbiter.
// master = requesters (CPU core + debug loader), slave = arbiter.
interface hc4_ram_arbiter_if
   import hc4_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_lock;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output host_req, host_we, host_addr, host_wdata, host_lock,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      input  host_gnt, host_rvalid, host_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_addr, host_wdata, host_lock,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      output host_gnt, host_rvalid, host_rdata
   );
endinterface

// File: rtl/hc4_ram_sp.sv
// hc4_ram_sp: single-port synchronous RAM, write-on-edge, 1-cycle registered read.
module hc4_ram_sp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage array and read register; contents survive reset.
   // NOTE: the array has no reset branch so it maps onto RAM macros; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/hc4_ram_arbiter.sv
// hc4_ram_arbiter: shares the HC4 data RAM between the CPU port and the host/debug port.
// Round-robin with a bounded host burst-lock. Define HC4_ARB_CPU_PRIORITY_EN for fixed
// CPU priority (host_lock ignored, burst state never entered).
module hc4_ram_arbiter
   import hc4_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                clk,
   input  logic                reset,
   hc4_ram_arbiter_if.slave    bus
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   state_t            state_q;
   owner_t            last_owner;
   logic [CNT_W-1:0]  burst_cnt;
   logic              cpu_gnt, host_gnt;
   logic              cpu_rvalid_q, host_rvalid_q;
   logic [DATA_W-1:0] cpu_hold, host_hold;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

`ifndef HC4_ARB_CPU_PRIORITY_EN
   // Host keeps ownership while it stays locked and requesting.
   logic burst_hold;
   assign burst_hold = (state_q == ST_BURST) && bus.host_req && bus.host_lock;
`endif

   // Grant decision for this cycle, from requests and registered arbiter state.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
`ifdef HC4_ARB_CPU_PRIORITY_EN
      cpu_gnt  = bus.cpu_req;
      host_gnt = bus.host_req && !bus.cpu_req;
`else
      if (burst_hold) begin
         if (bus.cpu_req && burst_cnt == CNT_W'(MAX_BURST)) cpu_gnt = 1'b1;
         else                                                host_gnt = 1'b1;
      end else if (bus.cpu_req && bus.host_req) begin
         cpu_gnt  = (last_owner == OWN_HOST);
         host_gnt = (last_owner == OWN_CPU);
      end else begin
         cpu_gnt  = bus.cpu_req;
         host_gnt = bus.host_req;
      end
`endif
   end

   assign ram_we    = (cpu_gnt && bus.cpu_we) || (host_gnt && bus.host_we);
   assign ram_addr  = host_gnt ? bus.host_addr  : bus.cpu_addr;
   assign ram_wdata = host_gnt ? bus.host_wdata : bus.cpu_wdata;

   hc4_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Arbiter FSM, burst counter, owner history and read-return steering.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         burst_cnt     <= '0;
         last_owner    <= OWN_HOST;
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         cpu_hold      <= '0;
         host_hold     <= '0;
      end else begin
         cpu_rvalid_q  <= cpu_gnt && !bus.cpu_we;
         host_rvalid_q <= host_gnt && !bus.host_we;
         if (cpu_rvalid_q)  cpu_hold  <= ram_rdata;
         if (host_rvalid_q) host_hold <= ram_rdata;
         if (cpu_gnt)       last_owner <= OWN_CPU;
         else if (host_gnt) last_owner <= OWN_HOST;
`ifdef HC4_ARB_CPU_PRIORITY_EN
         state_q   <= ST_IDLE;
         burst_cnt <= '0;
`else
         if (burst_hold) begin
            if (host_gnt) begin
               if (burst_cnt != CNT_W'(MAX_BURST)) burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
               state_q   <= ST_IDLE;
               burst_cnt <= '0;
            end
         end else if (host_gnt && bus.host_lock) begin
            state_q   <= ST_BURST;
            burst_cnt <= CNT_W'(1);
         end else begin
            state_q   <= ST_IDLE;
            burst_cnt <= '0;
         end
`endif
      end
   end

`ifdef HC4_ARB_CPU_PRIORITY_EN
   logic unused_cfg;
   assign unused_cfg = ^{bus.host_lock, state_q, last_owner, burst_cnt};
`endif

   assign bus.cpu_gnt     = cpu_gnt;
   assign bus.host_gnt    = host_gnt;
   assign bus.cpu_rvalid  = cpu_rvalid_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.cpu_rdata   = cpu_rvalid_q  ? ram_rdata : cpu_hold;
   assign bus.host_rdata  = host_rvalid_q ? ram_rdata : host_hold;
endmodule

// File: tb/tb_hc4_ram_arbiter.sv
// tb_hc4_ram_arbiter: scoreboard bench for hc4_ram_arbiter; a behavioural model predicts
// grants each cycle and queues expected read data, compared when rvalid appears.
module tb_hc4_ram_arbiter;

   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hc4_ram_arbiter_if bus ();

   hc4_ram_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [3:0] mdl_mem [256];
   bit         mdl_burst;
   int         mdl_cnt;
   bit         mdl_last_host;
   logic [3:0] cpu_q[$];
   logic [3:0] host_q[$];
   logic [3:0] cpu_hold_exp, host_hold_exp;
   int         cpu_gnt_count, host_gnt_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [3:0] cd,
                        input bit hr, input bit hw, input logic [7:0] ha, input logic [3:0] hd,
                        input bit hl);
      bus.cpu_req  = cr; bus.cpu_we  = cw; bus.cpu_addr  = ca; bus.cpu_wdata  = cd;
      bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
      bus.host_lock = hl;
   endtask

   function automatic void predict(output bit gc, output bit gh);
      gc = 1'b0;
      gh = 1'b0;
`ifdef HC4_ARB_CPU_PRIORITY_EN
      gc = bus.cpu_req;
      gh = bus.host_req && !bus.cpu_req;
`else
      if (mdl_burst && bus.host_req && bus.host_lock) begin
         if (bus.cpu_req && mdl_cnt >= MAXB) gc = 1'b1;
         else                                gh = 1'b1;
      end else if (bus.cpu_req && bus.host_req) begin
         if (mdl_last_host) gc = 1'b1;
         else               gh = 1'b1;
      end else begin
         gc = bus.cpu_req;
         gh = bus.host_req;
      end
`endif
   endfunction

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic tick();
      bit gc, gh;
      logic [3:0] d;
      @(negedge clk);
      predict(gc, gh);
      check("cpu_gnt", bus.cpu_gnt, gc);
      check("host_gnt", bus.host_gnt, gh);
      check("cpu_rvalid", bus.cpu_rvalid, cpu_q.size() != 0);
      check("host_rvalid", bus.host_rvalid, host_q.size() != 0);
      if (cpu_q.size() != 0) cpu_hold_exp = cpu_q.pop_front();
      if (host_q.size() != 0) host_hold_exp = host_q.pop_front();
      check("cpu_rdata", bus.cpu_rdata, cpu_hold_exp);
      check("host_rdata", bus.host_rdata, host_hold_exp);
      if (gc) cpu_gnt_count++;
      if (gh) host_gnt_count++;
      @(posedge clk);
      d = gc ? mdl_mem[bus.cpu_addr] : mdl_mem[bus.host_addr];
      if (gc && bus.cpu_we)  mdl_mem[bus.cpu_addr]  = bus.cpu_wdata;
      if (gh && bus.host_we) mdl_mem[bus.host_addr] = bus.host_wdata;
      if (reset) begin
         mdl_burst = 1'b0; mdl_cnt = 0; mdl_last_host = 1'b1;
         cpu_hold_exp = '0; host_hold_exp = '0;
      end else begin
         if (gc && !bus.cpu_we)  cpu_q.push_back(d);
         if (gh && !bus.host_we) host_q.push_back(d);
         if (gc) mdl_last_host = 1'b0;
         if (gh) mdl_last_host = 1'b1;
`ifndef HC4_ARB_CPU_PRIORITY_EN
         if (mdl_burst && bus.host_req && bus.host_lock) begin
            if (gh) mdl_cnt = (mdl_cnt < MAXB) ? mdl_cnt + 1 : MAXB;
            else begin mdl_burst = 1'b0; mdl_cnt = 0; end
         end else if (gh && bus.host_lock) begin
            mdl_burst = 1'b1; mdl_cnt = 1;
         end else begin
            mdl_burst = 1'b0; mdl_cnt = 0;
         end
`endif
      end
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0);
      repeat (n) tick();
   endtask

   initial begin
      mdl_burst = 1'b0; mdl_cnt = 0; mdl_last_host = 1'b1;
      cpu_hold_exp = '0; host_hold_exp = '0;
      cpu_gnt_count = 0; host_gnt_count = 0;
      reset = 1'b1;
      drive(0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0);
      @(posedge clk); #1;
      repeat (2) tick();
      reset = 1'b0;
      idle(1);

      // Preload, then host write 0xA @0x05 followed by CPU read @0x05
      drive(0, 0, 8'h00, 4'h0, 1, 1, 8'h20, 4'h3, 0); tick();
      drive(1, 1, 8'h10, 4'hC, 0, 0, 8'h00, 4'h0, 0); tick();
      drive(0, 0, 8'h00, 4'h0, 1, 1, 8'h05, 4'hA, 0); tick();
      drive(1, 0, 8'h05, 4'h0, 0, 0, 8'h00, 4'h0, 0); tick();
      idle(1);
      check("rd05_hold", bus.cpu_rdata, 4'hA);

      // Reset, then simultaneous reads: CPU first, host second
      reset = 1'b1; idle(1); reset = 1'b0;
      drive(1, 0, 8'h10, 4'h0, 1, 0, 8'h20, 4'h0, 0); tick();
      drive(0, 0, 8'h10, 4'h0, 1, 0, 8'h20, 4'h0, 0); tick();
      idle(2);
      check("both_rd_cpu", bus.cpu_rdata, 4'hC);
      check("both_rd_host", bus.host_rdata, 4'h3);

      // CPU takes one access so the host wins the next tie, then a locked burst of 6 ties
      drive(1, 0, 8'h05, 4'h0, 0, 0, 8'h00, 4'h0, 0); tick();
      cpu_gnt_count = 0; host_gnt_count = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 8'h05, 4'h0, 1, 1, 8'(8'h30 + i), 4'(i + 1), 1);
         tick();
      end
`ifndef HC4_ARB_CPU_PRIORITY_EN
      check("burst_cpu_cnt", cpu_gnt_count, 1);
      check("burst_host_cnt", host_gnt_count, 5);
`endif
      idle(1);

      // Host locked alone for 10 cycles: granted every cycle
      cpu_gnt_count = 0; host_gnt_count = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 8'h00, 4'h0, 1, 0, 8'(8'h30 + (i % 4)), 4'h0, 1);
         tick();
      end
      check("solo_host_cnt", host_gnt_count, 10);
      check("solo_cpu_cnt", cpu_gnt_count, 0);
      idle(1);

      // Reset during burst cycle 2 with a host read granted, then a tie
      drive(0, 0, 8'h00, 4'h0, 1, 0, 8'h31, 4'h0, 1); tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      drive(1, 0, 8'h05, 4'h0, 1, 0, 8'h32, 4'h0, 1); tick();
      idle(2);

      // Both request with lock for 8 cycles
      cpu_gnt_count = 0; host_gnt_count = 0;
      drive(1, 0, 8'h10, 4'h0, 1, 0, 8'h20, 4'h0, 1);
      repeat (8) tick();
`ifdef HC4_ARB_CPU_PRIORITY_EN
      check("prio_cpu_cnt", cpu_gnt_count, 8);
      check("prio_host_cnt", host_gnt_count, 0);
`endif
      idle(2);

      // Preload 0x40..0x47, then randomised traffic
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 8'h00, 4'h0, 1, 1, 8'(8'h40 + i), 4'(i * 3 + 1), 0);
         tick();
      end
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'(8'h40 + $urandom_range(0, 7)),
               4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               8'(8'h40 + $urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 49) == 0);
         tick();
      end
      reset = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
